// File: rtl/lcd_cmd_sequencer.sv
// Character-LCD (4-bit mode) sequencer: runs the power-on init nibbles, then
// sends each accepted byte as two E-strobed nibbles with exact cycle timing.
module lcd_cmd_sequencer #(
    parameter int unsigned T_POWERUP    = 750000,
    parameter int unsigned T_INIT_LONG  = 205000,
    parameter int unsigned T_INIT_SHORT = 5000,
    parameter int unsigned T_INIT_GAP   = 2000,
    parameter int unsigned T_SETUP      = 2,
    parameter int unsigned T_EN         = 12,
    parameter int unsigned T_NIB_GAP    = 50,
    parameter int unsigned T_CMD        = 2000,
    parameter int unsigned T_CLEAR      = 82000,
    parameter int unsigned CNT_W        = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       busy,
    output logic       sf_e,
    output logic       e,
    output logic       rs,
    output logic       rw,
    output logic [3:0] lcd_d
);

    typedef enum logic [3:0] {
        PWR_WAIT, INIT_SET, INIT_EN, INIT_WAIT, IDLE, SETUP, EN, NIB_GAP, POST_WAIT
    } state_t;

    // Counter load values: a state loaded with N-1 lasts exactly N cycles.
    localparam logic [CNT_W-1:0] L_POWERUP    = CNT_W'(T_POWERUP - 1);
    localparam logic [CNT_W-1:0] L_INIT_LONG  = CNT_W'(T_INIT_LONG - 1);
    localparam logic [CNT_W-1:0] L_INIT_SHORT = CNT_W'(T_INIT_SHORT - 1);
    localparam logic [CNT_W-1:0] L_INIT_GAP   = CNT_W'(T_INIT_GAP - 1);
    localparam logic [CNT_W-1:0] L_SETUP      = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] L_EN         = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] L_NIB_GAP    = CNT_W'(T_NIB_GAP - 1);
    localparam logic [CNT_W-1:0] L_CMD        = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] L_CLEAR      = CNT_W'(T_CLEAR - 1);
    // The accept cycle itself precedes the first setup, so E rises T_SETUP+1 after accept.
    localparam logic [CNT_W-1:0] L_SETUP_FIRST = CNT_W'(T_SETUP);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_init_idx;
    logic             r_low_phase;
    logic [3:0]       r_low_nib;
    logic             r_post_clear;
    logic             r_e;
    logic             r_rs;
    logic [3:0]       r_lcd_d;
    logic             r_ready;
    logic             r_init_done;
    logic             r_busy;
    logic [CNT_W-1:0] w_init_wait;

    always_comb begin
        w_init_wait = L_INIT_GAP;
        unique case (r_init_idx)
            2'd0:    w_init_wait = L_INIT_LONG;
            2'd1:    w_init_wait = L_INIT_SHORT;
            default: w_init_wait = L_INIT_GAP;
        endcase
    end

    // NOTE: all state and outputs update with non-blocking assignments so every
    // register samples pre-edge values; the reset branch covers every register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= PWR_WAIT;
            r_cnt        <= L_POWERUP;
            r_init_idx   <= 2'd0;
            r_low_phase  <= 1'b0;
            r_low_nib    <= 4'h0;
            r_post_clear <= 1'b0;
            r_e          <= 1'b0;
            r_rs         <= 1'b0;
            r_lcd_d      <= 4'h0;
            r_ready      <= 1'b0;
            r_init_done  <= 1'b0;
            r_busy       <= 1'b1;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else begin
            unique case (r_state)
                PWR_WAIT: begin
                    r_state    <= INIT_SET;
                    r_cnt      <= L_SETUP;
                    r_init_idx <= 2'd0;
                    r_rs       <= 1'b0;
                    r_lcd_d    <= 4'h3;
                end
                INIT_SET: begin
                    r_state <= INIT_EN;
                    r_cnt   <= L_EN;
                    r_e     <= 1'b1;
                end
                INIT_EN: begin
                    r_state <= INIT_WAIT;
                    r_cnt   <= w_init_wait;
                    r_e     <= 1'b0;
                end
                INIT_WAIT: begin
                    if (r_init_idx == 2'd3) begin
                        r_state     <= IDLE;
                        r_init_done <= 1'b1;
                        r_ready     <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_state    <= INIT_SET;
                        r_cnt      <= L_SETUP;
                        r_init_idx <= r_init_idx + 2'd1;
                        r_lcd_d    <= (r_init_idx == 2'd2) ? 4'h2 : 4'h3;
                    end
                end
                IDLE: begin
                    if (req_valid && r_ready) begin
                        r_state      <= SETUP;
                        r_cnt        <= L_SETUP_FIRST;
                        r_ready      <= 1'b0;
                        r_busy       <= 1'b1;
                        r_low_phase  <= 1'b0;
                        r_rs         <= req_rs;
                        r_lcd_d      <= req_data[7:4];
                        r_low_nib    <= req_data[3:0];
                        r_post_clear <= !req_rs && (req_data[7:1] == 7'd0);
                    end
                end
                SETUP: begin
                    r_state <= EN;
                    r_cnt   <= L_EN;
                    r_e     <= 1'b1;
                end
                EN: begin
                    r_e <= 1'b0;
                    if (r_low_phase) begin
                        r_state <= POST_WAIT;
                        r_cnt   <= r_post_clear ? L_CLEAR : L_CMD;
                    end else begin
                        r_state <= NIB_GAP;
                        r_cnt   <= L_NIB_GAP;
                    end
                end
                NIB_GAP: begin
                    r_state     <= SETUP;
                    r_cnt       <= L_SETUP;
                    r_low_phase <= 1'b1;
                    r_lcd_d     <= r_low_nib;
                end
                POST_WAIT: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= PWR_WAIT;
                    r_cnt   <= L_POWERUP;
                    r_e     <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign init_done = r_init_done;
    assign busy      = r_busy;
    assign sf_e      = 1'b1;
    assign e         = r_e;
    assign rs        = r_rs;
    assign rw        = 1'b0;
    assign lcd_d     = r_lcd_d;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Self-checking bench for lcd_cmd_sequencer: a negedge monitor records every E
// pulse, and each test compares them with timing computed from the rules.
module tb_lcd_cmd_sequencer;

    localparam int P_PWR   = 20;
    localparam int P_LONG  = 10;
    localparam int P_SHORT = 6;
    localparam int P_GAP   = 4;
    localparam int P_S     = 2;
    localparam int P_E     = 3;
    localparam int P_G     = 4;
    localparam int P_CMD   = 5;
    localparam int P_CLR   = 12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_rs;
    logic [7:0] req_data;
    logic       req_ready, init_done, busy, sf_e, e, rs, rw;
    logic [3:0] lcd_d;

    typedef struct {
        logic [3:0] nib;
        logic       rs;
        int         rise;
        int         width;
    } pulse_t;

    pulse_t pq[$];
    pulse_t cur;
    bit     prev_e = 1'b0;
    bit     mon_en = 1'b0;
    int     cyc = 0;
    int     n_checks = 0;
    int     n_errors = 0;

    lcd_cmd_sequencer #(
        .T_POWERUP(P_PWR), .T_INIT_LONG(P_LONG), .T_INIT_SHORT(P_SHORT),
        .T_INIT_GAP(P_GAP), .T_SETUP(P_S), .T_EN(P_E), .T_NIB_GAP(P_G),
        .T_CMD(P_CMD), .T_CLEAR(P_CLR), .CNT_W(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_rs(req_rs),
        .req_data(req_data), .req_ready(req_ready), .init_done(init_done),
        .busy(busy), .sf_e(sf_e), .e(e), .rs(rs), .rw(rw), .lcd_d(lcd_d)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference rules
    function automatic int post_of(input logic r, input logic [7:0] d);
        return (!r && d[7:1] == 7'd0) ? P_CLR : P_CMD;
    endfunction

    function automatic int init_wait(input int k);
        return (k == 0) ? P_LONG : (k == 1) ? P_SHORT : P_GAP;
    endfunction

    function automatic logic [3:0] init_nib(input int k);
        return (k == 3) ? 4'h2 : 4'h3;
    endfunction

    // Pulse recorder plus always-on pin checks
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (rw !== 1'b0 || sf_e !== 1'b1) begin
                n_errors++;
                $display("FAIL const_pins @%0d: rw=%b sf_e=%b required rw=0 sf_e=1", cyc, rw, sf_e);
            end
            n_checks++;
            if (busy !== !req_ready) begin
                n_errors++;
                $display("FAIL busy_vs_ready @%0d: busy=%b ready=%b required busy=!ready", cyc, busy, req_ready);
            end
            n_checks++;
            if (req_ready === 1'b1 && init_done !== 1'b1) begin
                n_errors++;
                $display("FAIL ready_before_init @%0d: ready=1 init_done=%b required init_done=1", cyc, init_done);
            end
            if (e === 1'b1 && !prev_e) begin
                cur.nib = lcd_d; cur.rs = rs; cur.rise = cyc; cur.width = 1;
            end else if (prev_e) begin
                n_checks++;
                if (lcd_d !== cur.nib || rs !== cur.rs) begin
                    n_errors++;
                    $display("FAIL bus_hold @%0d: lcd_d=%h rs=%b required lcd_d=%h rs=%b", cyc, lcd_d, rs, cur.nib, cur.rs);
                end
                if (e === 1'b1) cur.width++;
                else pq.push_back(cur);
            end
            prev_e = (e === 1'b1);
        end else begin
            prev_e = 1'b0;
        end
    end

    task automatic wait_ready(input int budget, output int edge_c, output bit ok);
        ok = 1'b0;
        edge_c = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                edge_c = cyc;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic check_init(input int rel);
        int rdy;
        bit ok;
        int exp_rise;
        wait_ready(1000, rdy, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL init_timeout: ready=0 after 1000 cycles, required ready=1");
            return;
        end
        n_checks++;
        if (init_done !== 1'b1) begin
            n_errors++;
            $display("FAIL init_done: got %b required 1", init_done);
        end
        n_checks++;
        if (pq.size() != 4) begin
            n_errors++;
            $display("FAIL init_pulse_count: got %0d required 4", pq.size());
        end
        exp_rise = rel + P_PWR + P_S;
        for (int k = 0; k < 4; k++) begin
            if (k < pq.size()) begin
                n_checks++;
                if (pq[k].nib !== init_nib(k) || pq[k].rs !== 1'b0) begin
                    n_errors++;
                    $display("FAIL init_nib%0d: got %h rs=%b required %h rs=0", k, pq[k].nib, pq[k].rs, init_nib(k));
                end
                n_checks++;
                if (pq[k].rise != exp_rise) begin
                    n_errors++;
                    $display("FAIL init_rise%0d: got %0d required %0d", k, pq[k].rise, exp_rise);
                end
                n_checks++;
                if (pq[k].width != P_E) begin
                    n_errors++;
                    $display("FAIL init_width%0d: got %0d required %0d", k, pq[k].width, P_E);
                end
            end
            if (k < 3) exp_rise += P_E + init_wait(k) + P_S;
        end
        n_checks++;
        if (rdy != exp_rise + P_E + init_wait(3)) begin
            n_errors++;
            $display("FAIL init_ready_edge: got %0d required %0d", rdy, exp_rise + P_E + init_wait(3));
        end
    endtask

    task automatic send_and_check(input logic r, input logic [7:0] d);
        int acc, rdy, post, rise_hi, rise_lo;
        bit ok;
        pq.delete();
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_send_ready: got %b required 1", req_ready);
        end
        req_valid = 1'b1; req_rs = r; req_data = d;
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid = 1'b0; req_rs = 1'($urandom); req_data = 8'($urandom);
        wait_ready(500, rdy, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL byte_timeout %h: ready=0 after 500 cycles, required ready=1", d);
            return;
        end
        post    = post_of(r, d);
        rise_hi = acc + P_S + 1;
        rise_lo = rise_hi + P_E + P_G + P_S;
        n_checks++;
        if (pq.size() != 2) begin
            n_errors++;
            $display("FAIL byte_pulse_count %h: got %0d required 2", d, pq.size());
        end
        if (pq.size() >= 1) begin
            n_checks++;
            if (pq[0].nib !== d[7:4] || pq[0].rs !== r || pq[0].rise != rise_hi || pq[0].width != P_E) begin
                n_errors++;
                $display("FAIL high_nibble %h: got nib=%h rs=%b rise=%0d w=%0d required nib=%h rs=%b rise=%0d w=%0d",
                         d, pq[0].nib, pq[0].rs, pq[0].rise, pq[0].width, d[7:4], r, rise_hi, P_E);
            end
        end
        if (pq.size() >= 2) begin
            n_checks++;
            if (pq[1].nib !== d[3:0] || pq[1].rs !== r || pq[1].rise != rise_lo || pq[1].width != P_E) begin
                n_errors++;
                $display("FAIL low_nibble %h: got nib=%h rs=%b rise=%0d w=%0d required nib=%h rs=%b rise=%0d w=%0d",
                         d, pq[1].nib, pq[1].rs, pq[1].rise, pq[1].width, d[3:0], r, rise_lo, P_E);
            end
        end
        n_checks++;
        if (rdy - acc != 2 * (P_S + P_E) + P_G + post + 1) begin
            n_errors++;
            $display("FAIL accept_to_ready %h rs=%b: got %0d required %0d", d, r, rdy - acc, 2 * (P_S + P_E) + P_G + post + 1);
        end
    endtask

    task automatic test_reset();
        int rel;
        rst_n = 1'b0; req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (e !== 1'b0 || rs !== 1'b0 || rw !== 1'b0 || lcd_d !== 4'h0 || sf_e !== 1'b1 ||
            req_ready !== 1'b0 || init_done !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_outputs: e=%b rs=%b rw=%b d=%h sf_e=%b rdy=%b done=%b busy=%b required 0 0 0 0 1 0 0 1",
                     e, rs, rw, lcd_d, sf_e, req_ready, init_done, busy);
        end
        rst_n = 1'b1;
        rel = cyc;
        pq.delete();
        mon_en = 1'b1;
        check_init(rel);
    endtask

    task automatic test_data_byte();
        send_and_check(1'b1, 8'h43);
    endtask

    task automatic test_clear();
        send_and_check(1'b0, 8'h01);
        send_and_check(1'b0, 8'h0C);
        send_and_check(1'b0, 8'h00);
        send_and_check(1'b0, 8'h02);
        send_and_check(1'b1, 8'h01);
    endtask

    task automatic test_random();
        logic       r;
        logic [7:0] d;
        for (int i = 0; i < 24; i++) begin
            r = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            if (i % 4 == 0) begin
                r = 1'b0;
                d = 8'($urandom_range(0, 1));
            end
            send_and_check(r, d);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        logic [3:0] nibs [6];
        int acc [3];
        int idx, rdy, gap;
        bit ok;
        bytes = '{8'h28, 8'h06, 8'h0C};
        nibs  = '{4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC};
        idx = 0;
        pq.delete();
        @(negedge clk);
        req_valid = 1'b1; req_rs = 1'b0; req_data = bytes[0];
        for (int c = 0; c < 300 && idx < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (req_ready === 1'b1) begin
                @(posedge clk);
                #1;
                acc[idx] = cyc;
                idx++;
                if (idx < 3) req_data = bytes[idx];
                else req_valid = 1'b0;
            end
        end
        n_checks++;
        if (idx != 3) begin
            n_errors++;
            $display("FAIL b2b_handshakes: got %0d required 3", idx);
            req_valid = 1'b0;
            return;
        end
        wait_ready(500, rdy, ok);
        repeat (10) @(negedge clk);
        n_checks++;
        if (!ok || req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_final_ready: got %b required 1", req_ready);
        end
        n_checks++;
        if (pq.size() != 6) begin
            n_errors++;
            $display("FAIL b2b_pulse_count: got %0d required 6", pq.size());
        end
        for (int k = 0; k < 6 && k < pq.size(); k++) begin
            n_checks++;
            if (pq[k].nib !== nibs[k] || pq[k].rs !== 1'b0) begin
                n_errors++;
                $display("FAIL b2b_nib%0d: got %h rs=%b required %h rs=0", k, pq[k].nib, pq[k].rs, nibs[k]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            gap = 2 * (P_S + P_E) + P_G + post_of(1'b0, bytes[k]) + 2;
            n_checks++;
            if (acc[k+1] - acc[k] != gap) begin
                n_errors++;
                $display("FAIL b2b_accept_spacing%0d: got %0d required %0d", k, acc[k+1] - acc[k], gap);
            end
        end
    endtask

    task automatic test_reset_mid_byte();
        int rel;
        bit found;
        pq.delete();
        @(negedge clk);
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h43;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (e === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found || lcd_d !== 4'h4) begin
            n_errors++;
            $display("FAIL midrst_high_pulse: found=%b lcd_d=%h required found=1 lcd_d=4", found, lcd_d);
        end
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (e !== 1'b0 || req_ready !== 1'b0 || init_done !== 1'b0 || busy !== 1'b1 || lcd_d !== 4'h0) begin
            n_errors++;
            $display("FAIL midrst_async: e=%b rdy=%b done=%b busy=%b d=%h required 0 0 0 1 0",
                     e, req_ready, init_done, busy, lcd_d);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        pq.delete();
        mon_en = 1'b1;
        check_init(rel);
        repeat (40) @(negedge clk);
        n_checks++;
        if (pq.size() != 4 || req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_byte_discarded: pulses=%0d ready=%b required 4 and 1", pq.size(), req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_data_byte();
        test_clear();
        test_random();
        test_back_to_back();
        test_reset_mid_byte();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
